// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
//   Arbitrates icache and dcache word accesses onto a single-ported RAM.
//   The dcache has priority. A starvation counter forces an icache grant
//   after STARVE_MAX dcache words have been served while iREN was pending.
//   Dcache bursts of up to MAX_BURST words are served without letting the
//   icache in between them.
//
// Ports
//   CLK, nRST        clock (rising edge), asynchronous active-low reset
//   iREN/iaddr       icache read request and word address
//   iwait/iload      0 = iload valid, icache access complete
//   dREN/dWEN        dcache read / write request (write wins if both are set)
//   daddr/dstore     dcache word address and write data
//   dwait/dload      0 = dcache access complete (dload valid on a read)
//   ramREN/ramWEN    RAM read / write enables
//   ramaddr/ramstore RAM address and write data
//   ramload          RAM read data
//   ramstate         00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR
//   ram_err          sticky flag: RAM reported ERROR since reset
module cache_mem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int MAX_BURST  = 2
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic              ram_err
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);
    localparam logic [BW-1:0] BURST_LIM  = BW'(MAX_BURST);

    typedef enum logic [1:0] {
        IDLE,
        IGNT,
        DGNT,
        DHOLD
    } state_t;

    state_t        state, state_n;
    logic [SW-1:0] starve_cnt, starve_n;
    logic [BW-1:0] burst_cnt, burst_n;
    logic          err_n;

    logic dreq;
    logic starved;
    logic done;
    logic is_err;

    assign dreq    = dREN | dWEN;
    assign starved = (starve_cnt >= STARVE_LIM);
    // ACCESS and ERROR both end the access; ERROR additionally sets ram_err.
    assign done    = ramstate[1];
    assign is_err  = (ramstate == 2'b11);

    // Read data is passed straight through; it is only meaningful while the
    // matching wait is low.
    assign iload = ramload;
    assign dload = ramload;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state      <= IDLE;
            starve_cnt <= '0;
            burst_cnt  <= '0;
            ram_err    <= 1'b0;
        end else begin
            state      <= state_n;
            starve_cnt <= starve_n;
            burst_cnt  <= burst_n;
            ram_err    <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        starve_n = starve_cnt;
        burst_n  = burst_cnt;
        err_n    = ram_err;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        iwait    = 1'b1;
        dwait    = 1'b1;

        case (state)
            IDLE: begin
                if (iREN && (starved || !dreq)) begin
                    state_n = IGNT;
                end else if (dreq) begin
                    state_n = DGNT;
                    burst_n = '0;
                end
            end

            IGNT: begin
                // A dropped request abandons the access without completing it.
                if (!iREN) begin
                    state_n = IDLE;
                end else begin
                    ramREN  = 1'b1;
                    ramaddr = iaddr;
                    if (done) begin
                        iwait    = 1'b0;
                        starve_n = '0;
                        state_n  = IDLE;
                        if (is_err) begin
                            err_n = 1'b1;
                        end
                    end
                end
            end

            DGNT: begin
                if (!dreq) begin
                    state_n = IDLE;
                end else begin
                    ramaddr = daddr;
                    if (dWEN) begin
                        ramWEN   = 1'b1;
                        ramstore = dstore;
                    end else begin
                        ramREN = 1'b1;
                    end
                    if (done) begin
                        dwait   = 1'b0;
                        burst_n = burst_cnt + BW'(1);
                        if (iREN && !starved) begin
                            starve_n = starve_cnt + SW'(1);
                        end
                        state_n = DHOLD;
                        if (is_err) begin
                            err_n = 1'b1;
                        end
                    end
                end
            end

            DHOLD: begin
                // One idle cycle between dcache words lets the requester
                // present the next address; the burst continues only while
                // under the burst limit and the icache is not starved.
                if (dreq && (burst_cnt < BURST_LIM) && !(iREN && starved)) begin
                    state_n = DGNT;
                end else begin
                    state_n = IDLE;
                    burst_n = '0;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule
